pkt_release_ctrl: RTL

PKT_RELEASE_CTRL -- requirements
Module: pkt_release_ctrl

---
 rtl/pkt_release_pkg.sv | 5 +
 rtl/pkt_release_stats.sv | 25 ++
 rtl/pkt_release_ctrl.sv | 89 ++++++++
 3 files changed

// File: rtl/pkt_release_pkg.sv
// pkt_release_pkg: shared state encoding and default verdict timeout for pkt_release_ctrl
package pkt_release_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, FWD = 2'd2, DROP = 2'd3} state_t;
  localparam int DEFAULT_TIMEOUT_CYCLES = 1024;
endpackage

// File: rtl/pkt_release_stats.sv
// pkt_release_stats: wrapping forward/drop/timeout event counters
module pkt_release_stats #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fwd_inc,
  input  logic                 drop_inc,
  input  logic                 timeout_inc,
  output logic [CNT_WIDTH-1:0] fwd_count,
  output logic [CNT_WIDTH-1:0] drop_count,
  output logic [CNT_WIDTH-1:0] timeout_count
);
  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_count     <= '0;
      drop_count    <= '0;
      timeout_count <= '0;
    end else begin
      fwd_count     <= fwd_count + CNT_WIDTH'(fwd_inc);
      drop_count    <= drop_count + CNT_WIDTH'(drop_inc);
      timeout_count <= timeout_count + CNT_WIDTH'(timeout_inc);
    end
  end
endmodule

// File: rtl/pkt_release_ctrl.sv
// pkt_release_ctrl: holds the head packet until a send/drop verdict (or timeout), then forwards or discards it.
// Statistics counters are built only when PKT_RELEASE_STATS_EN is defined; otherwise they read 0.
module pkt_release_ctrl #(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int TIMEOUT_CYCLES     = pkt_release_pkg::DEFAULT_TIMEOUT_CYCLES,
  parameter int CNT_WIDTH          = 32
) (
  input  logic                            axi_aclk,
  input  logic                            axi_reset,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                            s_axis_tlast,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                            m_axis_tlast,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  input  logic                            verdict_valid,
  input  logic                            verdict_send,
  output logic                            verdict_ready,
  output logic [CNT_WIDTH-1:0]            fwd_count,
  output logic [CNT_WIDTH-1:0]            drop_count,
  output logic [CNT_WIDTH-1:0]            timeout_count
);
  import pkt_release_pkg::*;
  localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit TO_EN = TIMEOUT_CYCLES > 0;
  state_t state;
  logic [TW-1:0] timer;
  logic live, fwd, drop, v_acc, timeout_evt, last_beat;
  // outputs are forced low for as long as reset is held, not just after the edge
  assign live          = !axi_reset;
  assign fwd           = live && state == FWD;
  assign drop          = live && state == DROP;
  assign verdict_ready = live && state == WAIT;
  assign s_axis_tready = fwd ? m_axis_tready : drop;
  assign m_axis_tvalid = fwd && s_axis_tvalid;
  assign m_axis_tdata  = fwd ? s_axis_tdata : '0;
  assign m_axis_tstrb  = fwd ? s_axis_tstrb : '0;
  assign m_axis_tuser  = fwd ? s_axis_tuser : '0;
  assign m_axis_tlast  = fwd && s_axis_tlast;
  assign v_acc         = verdict_valid && verdict_ready;
  assign timeout_evt   = TO_EN && verdict_ready && !verdict_valid && timer == TW'(TIMEOUT_CYCLES - 1);
  assign last_beat     = s_axis_tvalid && s_axis_tready && s_axis_tlast;
  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      state <= IDLE;
      timer <= '0;
    end else begin
      case (state)
        IDLE: if (s_axis_tvalid) begin
          state <= WAIT;
          timer <= '0;
        end
        WAIT: begin
          timer <= timer + TW'(1);
          if (v_acc) state <= verdict_send ? FWD : DROP;
          else if (timeout_evt) state <= DROP;
        end
        default: if (last_beat) state <= IDLE;
      endcase
    end
  end
`ifdef PKT_RELEASE_STATS_EN
  logic [CNT_WIDTH-1:0] fwd_c, drop_c, to_c;
  pkt_release_stats #(.CNT_WIDTH(CNT_WIDTH)) u_stats (
    .clk           (axi_aclk),
    .rst           (axi_reset),
    .fwd_inc       (v_acc && verdict_send),
    .drop_inc      ((v_acc && !verdict_send) || timeout_evt),
    .timeout_inc   (timeout_evt),
    .fwd_count     (fwd_c),
    .drop_count    (drop_c),
    .timeout_count (to_c)
  );
  assign fwd_count     = live ? fwd_c : '0;
  assign drop_count    = live ? drop_c : '0;
  assign timeout_count = live ? to_c : '0;
`else
  assign fwd_count     = '0;
  assign drop_count    = '0;
  assign timeout_count = '0;
`endif
endmodule
